butterfly_radix2_pipe: RTL and testbench

Pipelined, parametrised radix-2 complex butterfly for the FFT datapath. It supports per-transaction DIF or DIT mode, twiddle multiply, optional divide-by-2 stage scaling with rounding, and output saturation with a sticky overflow flag. It accepts one butterfly per clock with a Start/Done valid pair and fixed latency, and sits between the FFT memory read path and write-back.

---
 rtl/butterfly_radix2_pipe_if.sv | 26 ++
 rtl/butterfly_radix2_pipe.sv | 152 +++++++++++++++
 tb/tb_butterfly_radix2_pipe.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_radix2_pipe_if.sv
// Handshake and data bundle for the radix-2 butterfly: Start-qualified inputs,
// Done-qualified outputs and the sticky overflow flag.
interface butterfly_radix2_pipe_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16
);
  logic                     Start;
  logic                     Mode;
  logic                     Scale;
  logic                     Ovf_Clr;
  logic signed [DATA_W-1:0] X0_Re, X0_Im, X1_Re, X1_Im;
  logic signed [COEF_W-1:0] W_Re, W_Im;
  logic                     Done;
  logic                     Ovf;
  logic signed [DATA_W-1:0] Y0_Re, Y0_Im, Y1_Re, Y1_Im;

  modport master (
    output Start, Mode, Scale, Ovf_Clr, X0_Re, X0_Im, X1_Re, X1_Im, W_Re, W_Im,
    input  Done, Ovf, Y0_Re, Y0_Im, Y1_Re, Y1_Im
  );

  modport slave (
    input  Start, Mode, Scale, Ovf_Clr, X0_Re, X0_Im, X1_Re, X1_Im, W_Re, W_Im,
    output Done, Ovf, Y0_Re, Y0_Im, Y1_Re, Y1_Im
  );
endinterface

// File: rtl/butterfly_radix2_pipe.sv
// Pipelined radix-2 complex butterfly (DIF/DIT per transaction) with twiddle
// multiply, optional round-half-up halving, output saturation and sticky overflow.
module butterfly_radix2_pipe #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int STAGES = 3
) (
  input logic                    clk,
  input logic                    reset,
  butterfly_radix2_pipe_if.slave bus
);
  localparam int AW = DATA_W + 1;
  localparam int PW = DATA_W + COEF_W + 2;
  localparam int RW = PW - (COEF_W - 2);
  localparam int YW = DATA_W + 5;

  localparam logic signed [PW-1:0] RND_HALF = {{(PW-COEF_W+2){1'b0}}, 1'b1, {(COEF_W-3){1'b0}}};
  localparam logic signed [YW-1:0] ONE_Y    = {{(YW-1){1'b0}}, 1'b1};
  localparam logic signed [YW-1:0] MAXV     = {{(YW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [YW-1:0] MINV     = {{(YW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (STAGES != 3) begin : g_bad_stages
    $error("butterfly_radix2_pipe: only STAGES == 3 is supported");
  end

  function automatic logic signed [RW-1:0] rnd_prod(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] t;
    t = (p + RND_HALF) >>> (COEF_W - 2);
    return RW'(t);
  endfunction

  function automatic logic signed [YW-1:0] half_up(input logic signed [YW-1:0] v);
    return (v + ONE_Y) >>> 1;
  endfunction

  // MSB of the result flags that clipping happened.
  function automatic logic [DATA_W:0] sat(input logic signed [YW-1:0] v);
    if (v > MAXV)      return {1'b1, MAXV[DATA_W-1:0]};
    else if (v < MINV) return {1'b1, MINV[DATA_W-1:0]};
    else               return {1'b0, v[DATA_W-1:0]};
  endfunction

  logic                     vld_p0, vld_p1, vld_p2;
  logic                     mode_p0, mode_p1, scale_p0, scale_p1, scale_p2;
  logic signed [DATA_W-1:0] x0r_p0, x0i_p0, x1r_p0, x1i_p0;
  logic signed [COEF_W-1:0] wr_p0, wi_p0;
  logic signed [AW-1:0]     ar_p1, ai_p1;
  logic signed [PW-1:0]     pr_p1, pi_p1;
  logic signed [YW-1:0]     y0r_p2, y0i_p2, y1r_p2, y1i_p2;

  logic signed [AW-1:0] m_re, m_im, a_re, a_im;
  logic signed [PW-1:0] p_re, p_im;
  logic signed [RW-1:0] t_re, t_im;
  logic signed [YW-1:0] y0r, y0i, y1r, y1i;
  logic [DATA_W:0]      s_y0r, s_y0i, s_y1r, s_y1i;
  logic                 ovf_set;

  // ---- S1 -> S2: DIF multiplies the difference, DIT multiplies X1 and carries X0
  always_comb begin
    m_re = AW'(x1r_p0);
    m_im = AW'(x1i_p0);
    a_re = AW'(x0r_p0);
    a_im = AW'(x0i_p0);
    if (!mode_p0) begin
      m_re = AW'(x0r_p0) - AW'(x1r_p0);
      m_im = AW'(x0i_p0) - AW'(x1i_p0);
      a_re = AW'(x0r_p0) + AW'(x1r_p0);
      a_im = AW'(x0i_p0) + AW'(x1i_p0);
    end
    p_re = PW'(m_re) * PW'(wr_p0) - PW'(m_im) * PW'(wi_p0);
    p_im = PW'(m_re) * PW'(wi_p0) + PW'(m_im) * PW'(wr_p0);
  end

  // ---- S2 -> S3: round the product, combine with the carried term in DIT
  always_comb begin
    t_re = rnd_prod(pr_p1);
    t_im = rnd_prod(pi_p1);
    y0r  = YW'(ar_p1);
    y0i  = YW'(ai_p1);
    y1r  = YW'(t_re);
    y1i  = YW'(t_im);
    if (mode_p1) begin
      y0r = YW'(ar_p1) + YW'(t_re);
      y0i = YW'(ai_p1) + YW'(t_im);
      y1r = YW'(ar_p1) - YW'(t_re);
      y1i = YW'(ai_p1) - YW'(t_im);
    end
  end

  // ---- S3 -> output: optional halving, then saturation
  always_comb begin
    s_y0r   = sat(scale_p2 ? half_up(y0r_p2) : y0r_p2);
    s_y0i   = sat(scale_p2 ? half_up(y0i_p2) : y0i_p2);
    s_y1r   = sat(scale_p2 ? half_up(y1r_p2) : y1r_p2);
    s_y1i   = sat(scale_p2 ? half_up(y1i_p2) : y1i_p2);
    ovf_set = vld_p2 & (s_y0r[DATA_W] | s_y0i[DATA_W] | s_y1r[DATA_W] | s_y1i[DATA_W]);
  end

  always_ff @(posedge clk) begin
    if (bus.Start) begin
      x0r_p0   <= bus.X0_Re;
      x0i_p0   <= bus.X0_Im;
      x1r_p0   <= bus.X1_Re;
      x1i_p0   <= bus.X1_Im;
      wr_p0    <= bus.W_Re;
      wi_p0    <= bus.W_Im;
      mode_p0  <= bus.Mode;
      scale_p0 <= bus.Scale;
    end
    if (vld_p0) begin
      ar_p1    <= a_re;
      ai_p1    <= a_im;
      pr_p1    <= p_re;
      pi_p1    <= p_im;
      mode_p1  <= mode_p0;
      scale_p1 <= scale_p0;
    end
    if (vld_p1) begin
      y0r_p2   <= y0r;
      y0i_p2   <= y0i;
      y1r_p2   <= y1r;
      y1i_p2   <= y1i;
      scale_p2 <= scale_p1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      bus.Done  <= 1'b0;
      bus.Ovf   <= 1'b0;
      bus.Y0_Re <= '0;
      bus.Y0_Im <= '0;
      bus.Y1_Re <= '0;
      bus.Y1_Im <= '0;
    end else begin
      vld_p0   <= bus.Start;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1;
      bus.Done <= vld_p2;
      bus.Ovf  <= ovf_set | (bus.Ovf & ~bus.Ovf_Clr);
      if (vld_p2) begin
        bus.Y0_Re <= s_y0r[DATA_W-1:0];
        bus.Y0_Im <= s_y0i[DATA_W-1:0];
        bus.Y1_Re <= s_y1r[DATA_W-1:0];
        bus.Y1_Im <= s_y1i[DATA_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_butterfly_radix2_pipe.sv
// Scoreboard bench for butterfly_radix2_pipe: directed spec cases plus randomized
// traffic checked against an integer reference model.
module tb_butterfly_radix2_pipe;
  localparam int DW = 16;
  localparam int TW = 16;

  typedef struct {
    int due;
    int y0r, y0i, y1r, y1i;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   npass = 0;
  logic clr_s = 1'b0;
  bit   ovf_m = 1'b0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) clr_s <= bus.Ovf_Clr;

  butterfly_radix2_pipe_if #(.DATA_W(DW), .COEF_W(TW)) bus ();

  butterfly_radix2_pipe #(.DATA_W(DW), .COEF_W(TW), .STAGES(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic longint rnd(input longint p);
    return (p + (64'sd1 <<< (TW - 3))) >>> (TW - 2);
  endfunction

  function automatic longint fin(input longint v, input bit scale, inout bit sat);
    longint r;
    longint hi;
    longint lo;
    hi = (64'sd1 <<< (DW - 1)) - 1;
    lo = -(64'sd1 <<< (DW - 1));
    r = scale ? ((v + 1) >>> 1) : v;
    if (r > hi) begin r = hi; sat = 1'b1; end
    if (r < lo) begin r = lo; sat = 1'b1; end
    return r;
  endfunction

  // Butterfly evaluated directly from the arithmetic definition on wide integers.
  function automatic exp_t model(input bit mode, input bit scale, input int x0r, input int x0i,
                                 input int x1r, input int x1i, input int wr, input int wi);
    exp_t e;
    longint ar, ai, br, bi, mr, mi, y0r, y0i, y1r, y1i;
    bit s;
    s = 1'b0;
    if (!mode) begin
      mr = longint'(x0r) - x1r;
      mi = longint'(x0i) - x1i;
    end else begin
      mr = x1r;
      mi = x1i;
    end
    br = rnd(mr * wr - mi * wi);
    bi = rnd(mr * wi + mi * wr);
    if (!mode) begin
      ar = longint'(x0r) + x1r; ai = longint'(x0i) + x1i;
      y0r = ar; y0i = ai; y1r = br; y1i = bi;
    end else begin
      y0r = x0r + br; y0i = x0i + bi; y1r = x0r - br; y1i = x0i - bi;
    end
    e.due = 0;
    e.y0r = int'(fin(y0r, scale, s));
    e.y0i = int'(fin(y0i, scale, s));
    e.y1r = int'(fin(y1r, scale, s));
    e.y1i = int'(fin(y1i, scale, s));
    e.sat = s;
    return e;
  endfunction

  task automatic drive(input bit mode, input bit scale, input int x0r, input int x0i,
                       input int x1r, input int x1i, input int wr, input int wi, input bit clr);
    @(posedge clk);
    #1;
    bus.Start   = 1'b1;
    bus.Mode    = mode;
    bus.Scale   = scale;
    bus.Ovf_Clr = clr;
    bus.X0_Re   = DW'(x0r);
    bus.X0_Im   = DW'(x0i);
    bus.X1_Re   = DW'(x1r);
    bus.X1_Im   = DW'(x1i);
    bus.W_Re    = TW'(wr);
    bus.W_Im    = TW'(wi);
  endtask

  task automatic push(input int y0r, input int y0i, input int y1r, input int y1i, input bit sat);
    exp_t e;
    e.due = cyc + 4;
    e.y0r = y0r; e.y0i = y0i; e.y1r = y1r; e.y1i = y1i;
    e.sat = sat;
    q.push_back(e);
  endtask

  task automatic send_m(input bit mode, input bit scale, input int x0r, input int x0i,
                        input int x1r, input int x1i, input int wr, input int wi, input bit clr);
    exp_t e;
    drive(mode, scale, x0r, x0i, x1r, x1i, wr, wi, clr);
    e = model(mode, scale, x0r, x0i, x1r, x1i, wr, wi);
    push(e.y0r, e.y0i, e.y1r, e.y1i, e.sat);
  endtask

  task automatic idle(input int n, input bit clr);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.Start   = 1'b0;
      bus.Ovf_Clr = clr;
    end
  endtask

  function automatic int rs(input int w);
    logic [31:0] r;
    r = $urandom;
    return (w == 16) ? int'($signed(r[15:0])) : int'($signed(r[13:0]));
  endfunction

  // Monitor: every cycle compares Done and Ovf against the scoreboard, and the outputs on Done.
  always @(negedge clk) begin
    exp_t e;
    bit   due_now;
    bit   sat_now;
    if (!reset) begin
      ovf_m = 1'b0;
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        chk("done_missing", 0, 1);
        void'(q.pop_front());
      end
      due_now = (q.size() > 0) && (q[0].due == cyc);
      sat_now = 1'b0;
      chk("done", longint'(bus.Done), longint'(due_now));
      if (due_now) begin
        e = q.pop_front();
        chk("y0_re", longint'(bus.Y0_Re), e.y0r);
        chk("y0_im", longint'(bus.Y0_Im), e.y0i);
        chk("y1_re", longint'(bus.Y1_Re), e.y1r);
        chk("y1_im", longint'(bus.Y1_Im), e.y1i);
        sat_now = e.sat;
      end
      ovf_m = sat_now | (ovf_m & ~clr_s);
      chk("ovf", longint'(bus.Ovf), longint'(ovf_m));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Start = 1'b0; bus.Mode = 1'b0; bus.Scale = 1'b0; bus.Ovf_Clr = 1'b0;
    bus.X0_Re = '0; bus.X0_Im = '0; bus.X1_Re = '0; bus.X1_Im = '0;
    bus.W_Re = '0; bus.W_Im = '0;
    #1;
    chk("rst_done", longint'(bus.Done), 0);
    chk("rst_ovf", longint'(bus.Ovf), 0);
    chk("rst_y0_re", longint'(bus.Y0_Re), 0);
    chk("rst_y1_im", longint'(bus.Y1_Im), 0);
    #21 reset = 1'b1;
    idle(2, 1'b0);

    // Pass-through twiddle DIF, then -j twiddle DIF
    drive(1'b0, 1'b0, 1000, 200, 300, -100, 16384, 0, 1'b0);
    push(1300, 100, 700, 300, 1'b0);
    idle(5, 1'b0);
    drive(1'b0, 1'b0, 0, 0, 1000, 500, 0, -16384, 1'b0);
    push(1000, 500, -500, 1000, 1'b0);
    idle(4, 1'b0);

    // DIT unscaled and scaled
    drive(1'b1, 1'b0, 100, 0, 50, 0, 16384, 0, 1'b0);
    push(150, 0, 50, 0, 1'b0);
    drive(1'b1, 1'b1, 101, 0, 50, 0, 16384, 0, 1'b0);
    push(76, 0, 26, 0, 1'b0);
    idle(4, 1'b0);

    // Saturation, sticky hold, clear, then set coinciding with clear
    drive(1'b0, 1'b0, 30000, -30000, 30000, -30000, 16384, 0, 1'b0);
    push(32767, -32768, 0, 0, 1'b1);
    idle(13, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    drive(1'b0, 1'b0, 30000, -30000, 30000, -30000, 16384, 0, 1'b0);
    push(32767, -32768, 0, 0, 1'b1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(4, 1'b0);

    // Streaming with a one-cycle bubble
    send_m(1'b0, 1'b0, 1234, -567, -890, 321, 11585, -11585, 1'b0);
    send_m(1'b1, 1'b1, -20000, 15000, 12000, -9000, -16384, 0, 1'b0);
    send_m(1'b1, 1'b0, 32767, -32768, 32767, -32768, 16384, 16384, 1'b0);
    send_m(1'b0, 1'b1, -32768, -32768, 32767, 32767, -32768, 32767, 1'b0);
    idle(1, 1'b0);
    send_m(1'b1, 1'b0, -32768, 0, -32768, -32768, -32768, -32768, 1'b0);
    idle(5, 1'b1);
    idle(2, 1'b0);

    // Reset mid-flight: no Done for the dropped transaction, outputs cleared at once
    drive(1'b0, 1'b0, 500, 500, 100, 100, 16384, 0, 1'b0);
    @(posedge clk);
    #1 bus.Start = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_y0_re", longint'(bus.Y0_Re), 0);
    chk("arst_y0_im", longint'(bus.Y0_Im), 0);
    chk("arst_y1_re", longint'(bus.Y1_Re), 0);
    chk("arst_ovf", longint'(bus.Ovf), 0);
    chk("arst_done", longint'(bus.Done), 0);
    q.delete();
    #10 reset = 1'b1;
    idle(2, 1'b0);
    send_m(1'b1, 1'b0, 700, -300, 200, 100, 8192, -8192, 1'b0);
    idle(5, 1'b0);

    // Randomized traffic with random bubbles and clears
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        send_m(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs(16), rs(16), rs(16), rs(16),
               rs(16), rs(16), ($urandom_range(0, 15) == 0));
      else
        idle(1, ($urandom_range(0, 7) == 0));
    end
    idle(8, 1'b0);
    chk("drain", longint'(q.size()), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
